// File: rtl/wbm_tracelight.sv
// wbm_tracelight: passive Wishbone bus snooper that drives an 8-bit LED bus
// with live transaction status, and latches a sticky fault on ack timeouts or
// orphan acks. Nothing in here drives a Wishbone signal.
module wbm_tracelight #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int OW      = 3,
    parameter int STRETCH = 1024,
    parameter int TIMEOUT = 65535
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wb_cyc_o,
    input  logic            wb_stb_o,
    input  logic            wb_we_o,
    input  logic            wb_stall_i,
    input  logic            wb_ack_i,
    input  logic [DW/8-1:0] wb_sel_o,
    input  logic [AW-1:0]   wb_adr_o,
    input  logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [1:0]      mode_i,
    output logic [7:0]      blinkenlight,
    output logic            fault_o
);

    localparam int SW = $clog2(STRETCH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] OUT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    logic          accept, ack_ev, orphan, enter_fault;
    logic          req_led, ack_led;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [3:0]    ack_cnt_q, ack_cnt_d;
    logic          last_we_q, last_we_d;
    logic [7:0]    last_adr_q, last_adr_d;
    logic [7:0]    last_rd_q, last_rd_d;
    logic          wr_any_q, wr_any_d;
    logic          rd_any_q, rd_any_d;
    logic [SW-1:0] req_tmr_q, req_tmr_d;
    logic [SW-1:0] ack_tmr_q, ack_tmr_d;
    logic [TW-1:0] wait_q, wait_d;
    state_t        state_q, state_d;
    logic          fault_q, fault_d;
    logic [7:0]    blink_q, blink_d;

    // Byte selects and upper address bits are observed but carry no status.
    logic unused_inputs;
    assign unused_inputs = ^{wb_sel_o, wb_adr_o};

    assign accept  = wb_cyc_o & wb_stb_o & ~wb_stall_i;
    assign ack_ev  = wb_cyc_o & wb_ack_i;
    assign req_led = (req_tmr_q != '0);
    assign ack_led = (ack_tmr_q != '0);

    // Outstanding count, ack counter, captures and LED stretch timers.
    always_comb begin
        outstanding_d = outstanding_q;
        ack_cnt_d     = ack_cnt_q;
        last_we_d     = last_we_q;
        last_adr_d    = last_adr_q;
        last_rd_d     = last_rd_q;
        wr_any_d      = wr_any_q;
        rd_any_d      = rd_any_q;
        req_tmr_d     = req_tmr_q;
        ack_tmr_d     = ack_tmr_q;
        orphan        = 1'b0;

        if (ack_ev) ack_cnt_d = ack_cnt_q + 4'd1;

        // Dropping cyc abandons everything in flight.
        if (!wb_cyc_o) begin
            outstanding_d = '0;
        end else if (accept && !ack_ev) begin
            if (outstanding_q != OUT_MAX) outstanding_d = outstanding_q + 1'b1;
        end else if (ack_ev && !accept) begin
            if (outstanding_q == '0) orphan = 1'b1;
            else                     outstanding_d = outstanding_q - 1'b1;
        end

        if (accept) begin
            last_we_d  = wb_we_o;
            last_adr_d = wb_adr_o[7:0];
            wr_any_d   = |wb_dat_o;
            rd_any_d   = 1'b0;
        end
        // Read data is judged by the direction of the previously accepted
        // request; when both happen together the ack's rd_any wins.
        if (ack_ev && !last_we_q) begin
            last_rd_d = wb_dat_i[7:0];
            rd_any_d  = |wb_dat_i;
        end

        if (accept)                req_tmr_d = SW'(STRETCH);
        else if (req_tmr_q != '0)  req_tmr_d = req_tmr_q - 1'b1;
        if (ack_ev)                ack_tmr_d = SW'(STRETCH);
        else if (ack_tmr_q != '0)  ack_tmr_d = ack_tmr_q - 1'b1;
    end

    // FSM next state, ack wait counter and sticky fault.
    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        enter_fault = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !ack_ev) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wb_cyc_o || (outstanding_d == '0)) begin
                    state_d = ST_IDLE;
                end else if (!(accept || ack_ev)) begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == TW'(TIMEOUT)) begin
                        state_d     = ST_FAULT;
                        enter_fault = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (!wb_cyc_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        fault_d = fault_q | orphan | enter_fault;
    end

    // LED bus contents selected by mode_i from the registered state.
    always_comb begin
        blink_d = 8'h00;
        case (mode_i)
            2'd0: blink_d = {ack_cnt_q, req_led, last_we_q, wr_any_q, rd_any_q};
            2'd1: blink_d = {state_q, ack_led, 5'(outstanding_q)};
            2'd2: blink_d = last_adr_q;
            2'd3: blink_d = last_rd_q;
            default: blink_d = 8'h00;
        endcase
    end

    // All state registers with asynchronous active-low clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            outstanding_q <= '0;
            ack_cnt_q     <= '0;
            last_we_q     <= 1'b0;
            last_adr_q    <= '0;
            last_rd_q     <= '0;
            wr_any_q      <= 1'b0;
            rd_any_q      <= 1'b0;
            req_tmr_q     <= '0;
            ack_tmr_q     <= '0;
            wait_q        <= '0;
            state_q       <= ST_IDLE;
            fault_q       <= 1'b0;
            blink_q       <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            ack_cnt_q     <= ack_cnt_d;
            last_we_q     <= last_we_d;
            last_adr_q    <= last_adr_d;
            last_rd_q     <= last_rd_d;
            wr_any_q      <= wr_any_d;
            rd_any_q      <= rd_any_d;
            req_tmr_q     <= req_tmr_d;
            ack_tmr_q     <= ack_tmr_d;
            wait_q        <= wait_d;
            state_q       <= state_d;
            fault_q       <= fault_d;
            blink_q       <= blink_d;
        end
    end

    assign blinkenlight = blink_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_wbm_tracelight.sv
// Testbench for wbm_tracelight: directed scenarios with hand-derived values
// plus randomized traffic checked against an event-timestamp reference model.
module tb_wbm_tracelight;

    localparam int DW      = 32;
    localparam int AW      = 16;
    localparam int OW      = 3;
    localparam int STRETCH = 5;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, stall = 1'b0, ack = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [15:0] adr = 16'h0;
    logic [31:0] dato = 32'h0, dati = 32'h0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  blink;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    wbm_tracelight #(.DW(DW), .AW(AW), .OW(OW), .STRETCH(STRETCH), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
        .wb_stall_i(stall), .wb_ack_i(ack),
        .wb_sel_o(sel), .wb_adr_o(adr), .wb_dat_o(dato), .wb_dat_i(dati),
        .mode_i(mode), .blinkenlight(blink), .fault_o(fault)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers; LEDs from timestamps of last events,
    // state derived from the fault flag and the outstanding count.
    int   m_outs, m_ackcnt, m_quiet, m_t, m_lacc, m_lack, m_adr, m_lrd;
    bit   m_infault, m_fault, m_lwe, m_wr, m_rd;
    logic [7:0] exp_blink;
    logic       exp_fault;

    task automatic model_reset();
        m_outs = 0; m_ackcnt = 0; m_quiet = 0; m_t = 0;
        m_lacc = -1000; m_lack = -1000; m_adr = 0; m_lrd = 0;
        m_infault = 0; m_fault = 0; m_lwe = 0; m_wr = 0; m_rd = 0;
    endtask

    function automatic logic [7:0] m_display(input logic [1:0] md);
        int v;
        int st;
        bit rl, al;
        st = m_infault ? 2 : ((m_outs > 0) ? 1 : 0);
        rl = (m_t - m_lacc) < STRETCH;
        al = (m_t - m_lack) < STRETCH;
        case (md)
            2'd0:    v = m_ackcnt * 16 + (rl ? 8 : 0) + (m_lwe ? 4 : 0) + (m_wr ? 2 : 0) + (m_rd ? 1 : 0);
            2'd1:    v = st * 64 + (al ? 32 : 0) + (m_outs % 32);
            2'd2:    v = m_adr;
            default: v = m_lrd;
        endcase
        return 8'(v);
    endfunction

    task automatic model_step();
        bit acc, ak, old_lwe;
        int st;
        acc = cyc && stb && !stall;
        ak  = cyc && ack;
        exp_blink = m_display(mode);
        st = m_infault ? 2 : ((m_outs > 0) ? 1 : 0);
        old_lwe = m_lwe;
        if (ak) m_ackcnt = (m_ackcnt + 1) % 16;
        if (acc) begin
            m_lwe = we; m_adr = int'(adr[7:0]); m_wr = (dato != 0); m_rd = 0;
        end
        if (ak && !old_lwe) begin
            m_lrd = int'(dati[7:0]); m_rd = (dati != 0);
        end
        if (!cyc) m_outs = 0;
        else if (acc && !ak) m_outs = (m_outs < (1 << OW) - 1) ? m_outs + 1 : m_outs;
        else if (ak && !acc) begin
            if (m_outs == 0) m_fault = 1;
            else m_outs = m_outs - 1;
        end
        if (st == 1 && cyc && m_outs > 0 && !acc && !ak) begin
            m_quiet = m_quiet + 1;
            if (m_quiet == TIMEOUT) begin
                m_infault = 1; m_fault = 1; m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
        if (st == 2 && !cyc) m_infault = 0;
        m_t = m_t + 1;
        if (acc) m_lacc = m_t;
        if (ak)  m_lack = m_t;
        exp_fault = m_fault;
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic st,
                         input logic a, input logic [15:0] ad, input logic [31:0] dw,
                         input logic [31:0] dr, input logic [1:0] md);
        @(negedge clk);
        cyc = c; stb = s; we = w; stall = st; ack = a;
        adr = ad; dato = dw; dati = dr; mode = md; sel = 4'($urandom);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; stall = 0; ack = 0; adr = 0; dato = 0; dati = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL reset_blink: got %h want 00", blink); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
        @(negedge clk);
        cyc = 1; ack = 1; stb = 1; mode = 2'd1;
        @(posedge clk); #1;
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_hold_fault: got %b want 0", fault); end
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL reset_hold_blink: got %h want 00", blink); end
        apply_reset();
    endtask

    task automatic test_single_write();
        apply_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 32'h1, 32'h0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'h0E) begin n_bad++; $display("FAIL wr_after_accept: got %h want 0e", blink); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'hFF, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'h1E) begin n_bad++; $display("FAIL wr_after_ack: got %h want 1e", blink); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'h1E) begin n_bad++; $display("FAIL wr_stretch_last: got %h want 1e", blink); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'h16) begin n_bad++; $display("FAIL wr_stretch_end: got %h want 16", blink); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd2);
        n_cmp++; if (blink !== 8'h12) begin n_bad++; $display("FAIL wr_last_adr: got %h want 12", blink); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL wr_fault: got %b want 0", fault); end
    endtask

    task automatic test_pipelined_reads();
        logic [7:0] want [7];
        want = '{8'h41, 8'h42, 8'h43, 8'h62, 8'h61, 8'h20, 8'hA5};
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 32'h0, 32'h0, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0021, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== want[0]) begin n_bad++; $display("FAIL rd_out1: got %h want %h", blink, want[0]); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0022, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== want[1]) begin n_bad++; $display("FAIL rd_out2: got %h want %h", blink, want[1]); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h11, 2'd1);
        n_cmp++; if (blink !== want[2]) begin n_bad++; $display("FAIL rd_out3: got %h want %h", blink, want[2]); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h22, 2'd1);
        n_cmp++; if (blink !== want[3]) begin n_bad++; $display("FAIL rd_ack1: got %h want %h", blink, want[3]); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'hA5, 2'd1);
        n_cmp++; if (blink !== want[4]) begin n_bad++; $display("FAIL rd_ack2: got %h want %h", blink, want[4]); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== want[5]) begin n_bad++; $display("FAIL rd_ack3: got %h want %h", blink, want[5]); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd3);
        n_cmp++; if (blink !== want[6]) begin n_bad++; $display("FAIL rd_last_rd: got %h want %h", blink, want[6]); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rd_fault: got %b want 0", fault); end
    endtask

    task automatic test_stall();
        apply_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL stall_held: got %h want 00", blink); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h41) begin n_bad++; $display("FAIL stall_release: got %h want 41", blink); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h41) begin n_bad++; $display("FAIL stall_once: got %h want 41", blink); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
    endtask

    task automatic test_timeout();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", fault); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL to_fault: got %b want 1", fault); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h81) begin n_bad++; $display("FAIL to_state: got %h want 81", blink); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL to_idle: got %h want 00", blink); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", fault); end
    endtask

    task automatic test_orphan_wrap();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL orphan_fault: got %b want 1", fault); end
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'hF0) begin n_bad++; $display("FAIL ackcnt_15: got %h want f0", blink); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0);
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL ackcnt_wrap: got %h want 00", blink); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL orphan_sticky: got %b want 1", fault); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h41) begin n_bad++; $display("FAIL ar_wait: got %h want 41", blink); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (blink !== 8'h00) begin n_bad++; $display("FAIL ar_blink: got %h want 00", blink); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL ar_fault: got %b want 0", fault); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL ar_inflight_ack: got %b want 1", fault); end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd1);
        n_cmp++; if (blink !== 8'h20) begin n_bad++; $display("FAIL ar_outs_zero: got %h want 20", blink); end
    endtask

    task automatic test_random(input int stb_pct, input int ack_pct, input int ncyc);
        apply_reset();
        for (int i = 0; i < ncyc; i++) begin
            drive(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 99) < stb_pct),
                  1'($urandom), logic'($urandom_range(0, 3) == 0),
                  logic'($urandom_range(0, 99) < ack_pct), 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom), 2'($urandom));
            n_cmp++;
            if (blink !== exp_blink) begin
                n_bad++; $display("FAIL rand_blink cycle %0d: got %h want %h", i, blink, exp_blink);
            end
            n_cmp++;
            if (fault !== exp_fault) begin
                n_bad++; $display("FAIL rand_fault cycle %0d: got %b want %b", i, fault, exp_fault);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_pipelined_reads();
        test_stall();
        test_timeout();
        test_orphan_wrap();
        test_async_reset();
        test_random(50, 35, 300);
        test_random(70, 10, 300);
        test_random(10, 5, 300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
